// File: rtl/sum16_ctrl.sv
// rtl/sum16_ctrl.sv - two-requester adder that reuses one 4-bit ripple adder per nibble
// sum4b is the shared nibble adder; sum16_ctrl arbitrates, sequences nibbles and holds results.

module sum4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];

endmodule

module sum16_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [4*NIBBLES-1:0] a0,
  input  logic [4*NIBBLES-1:0] b0,
  input  logic                 ci0,
  input  logic                 req1,
  input  logic [4*NIBBLES-1:0] a1,
  input  logic [4*NIBBLES-1:0] b1,
  input  logic                 ci1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 done0,
  output logic                 done1,
  output logic [4*NIBBLES-1:0] s,
  output logic                 co,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic [KW-1:0] k;
  logic          owner;
  logic          last;

  logic          grant0;
  logic          grant1;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [3:0]    nib_sum;
  logic          nib_co;

  // On a tie the requester that was not served last wins.
  assign grant1 = req1 & (~req0 | ~last);
  assign grant0 = req0 & ~grant1;
  assign ack0   = rst_n & (state == IDLE) & grant0;
  assign ack1   = rst_n & (state == IDLE) & grant1;

  assign done0 = (state == DONE) & ~owner;
  assign done1 = (state == DONE) &  owner;
  assign busy  = (state != IDLE);

  assign a_sh = a_reg >> {k, 2'b00};
  assign b_sh = b_reg >> {k, 2'b00};

  sum4b u_sum4b (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .ci (carry),
    .s  (nib_sum),
    .co (nib_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      k     <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
      s     <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ack0 | ack1) begin
            a_reg <= ack1 ? a1 : a0;
            b_reg <= ack1 ? b1 : b0;
            carry <= ack1 ? ci1 : ci0;
            owner <= ack1;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (k == KW'(i)) s[4*i +: 4] <= nib_sum;
          end
          carry <= nib_co;
          if (k == KW'(NIBBLES - 1)) begin
            co    <= nib_co;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum16_ctrl.sv
// tb/tb_sum16_ctrl.sv - scoreboard bench for sum16_ctrl with directed vectors
module tb_sum16_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, ci0, ci1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1, done0, done1, co, busy;
  logic [15:0] s;

  typedef struct {
    bit          who;
    logic [15:0] s;
    logic        co;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_ack = 0;

  sum16_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .ci0(ci0),
    .req1(req1), .a1(a1), .b1(b1), .ci1(ci1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .s(s), .co(co), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (done0 | done1) begin
      check("done_exclusive", {31'd0, done0 & done1}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_owner", {31'd0, done1}, {31'd0, e.who});
        check("sum", {16'd0, s}, {16'd0, e.s});
        check("carry_out", {31'd0, co}, {31'd0, e.co});
        check("done_latency", cyc, e.due);
        check("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
    if (ack0 & ack1) check("ack_exclusive", 32'd1, 32'd0);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input bit who, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [15:0] es, input logic eco,
                       input bit expect_done);
    bit got = 0;
    @(posedge clk); #1;
    if (who) begin req1 = 1; a1 = a; b1 = b; ci1 = ci; end
    else     begin req0 = 1; a0 = a; b0 = b; ci0 = ci; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (who ? ack1 : ack0) begin
        got = 1;
        last_ack = cyc;
        if (expect_done) sb.push_back('{who, es, eco, cyc + 5});
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    // Operands change right after capture; the result must not follow them.
    if (who) begin req1 = 0; a1 = ~a; b1 = ~b; ci1 = ~ci; end
    else     begin req0 = 0; a0 = ~a; b0 = ~b; ci0 = ~ci; end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  acks;
    bit  want;
    bit  got;
    rst_n = 1'b0;
    req0 = 1; req1 = 0; ci0 = 0; ci1 = 0;
    a0 = 16'h1234; b0 = 16'h4321; a1 = 0; b1 = 0;

    // Reset held two cycles with req0 raised.
    repeat (2) begin
      @(negedge clk);
      check("rst_ack0", {31'd0, ack0}, 32'd0);
      check("rst_done0", {31'd0, done0}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_co", {31'd0, co}, 32'd0);
    req0 = 0;
    @(posedge clk); #1 rst_n = 1'b1;

    issue(0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1);
    @(negedge clk);
    check("busy_run", {31'd0, busy}, 32'd1);
    wait_idle();
    check("hold_s", {16'd0, s}, 32'h5555);

    issue(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1);
    wait_idle();
    issue(0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1);
    wait_idle();
    issue(1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1);
    wait_idle();
    issue(0, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1);
    wait_idle();
    issue(1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1);
    wait_idle();
    issue(0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1);

    // req1 raised while requester 0 is running: no ack until IDLE.
    req1 = 1; a1 = 16'h0102; b1 = 16'h0304; ci1 = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack1) begin
        got = 1;
        check("busy_ack1_cycle", cyc, last_ack + 6);
        sb.push_back('{1'b1, 16'h0406, 1'b0, cyc + 5});
      end
    end
    if (!got) check("busy_ack1_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 req1 = 0;
    wait_idle();

    // Tie after reset alternates 0,1,0,1.
    do_reset();
    a0 = 16'h0001; b0 = 16'h0002; ci0 = 0;
    a1 = 16'h7FFF; b1 = 16'h0001; ci1 = 1;
    req0 = 1; req1 = 1;
    acks = 0; want = 0;
    for (int i = 0; i < 100 && acks < 4; i++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        check("tie_order", {31'd0, ack1}, {31'd0, want});
        if (acks > 0) check("tie_gap", cyc, last_ack + 6);
        last_ack = cyc;
        if (ack1) sb.push_back('{1'b1, 16'h8001, 1'b0, cyc + 5});
        else      sb.push_back('{1'b0, 16'h0003, 1'b0, cyc + 5});
        want = ~want;
        acks++;
      end
    end
    check("tie_ack_count", acks, 4);
    @(posedge clk); #1 req0 = 0; req1 = 0;
    wait_idle();

    // Reset in the second RUN cycle aborts with no done pulse.
    do_reset();
    issue(0, 16'h2222, 16'h3333, 1'b0, 16'h5555, 1'b0, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_s", {16'd0, s}, 32'd0);
    check("abort_co", {31'd0, co}, 32'd0);
    repeat (10) @(negedge clk);

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sum16_ctrl.md
SUM16_CTRL -- requirements
Module: sum16_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req0  input  1  requester 0 requests an addition.
REQ-005 SHALL have port a0  input  W  requester 0 operand A.
REQ-006 SHALL have port b0  input  W  requester 0 operand B.
REQ-007 SHALL have port ci0  input  1  requester 0 carry-in.
REQ-008 SHALL have port req1  input  1  requester 1 request.
REQ-009 SHALL have port a1  input  W  requester 1 operand A.
REQ-010 SHALL have port b1  input  W  requester 1 operand B.
REQ-011 SHALL have port ci1  input  1  requester 1 carry-in.
REQ-012 SHALL have port ack0  output  1  operands of requester 0 captured this cycle.
REQ-013 SHALL have port ack1  output  1  operands of requester 1 captured this cycle.
REQ-014 SHALL have port done0  output  1  result for requester 0 valid this cycle.
REQ-015 SHALL have port done1  output  1  result for requester 1 valid this cycle.
REQ-016 SHALL have port s  output  W  sum register.
REQ-017 SHALL have port co  output  1  final carry-out register.
REQ-018 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-019 SHALL instantiate exactly one existing 4-bit ripple adder (sum4b) and time-multiplex it, one nibble per cycle, LSB nibble first.
REQ-020 SHALL implement FSM states IDLE, RUN, DONE.
REQ-021 IDLE: if req0 or req1 high, SHALL assert the winner's ack combinationally that cycle, latch the winner's a, b, ci into operand/carry registers, record owner, clear nibble index, go to RUN; otherwise stay IDLE.
REQ-022 Arbitration SHALL be round-robin: single request wins; on simultaneous requests the requester not served last wins; last-served resets to 1 (requester 0 wins the first tie).
REQ-023 RUN: each cycle SHALL add nibble k of A and B with carry register, write the 4-bit result into s[4k+3:4k], load carry register with adder Co, increment k.
REQ-024 RUN SHALL exit to DONE after nibble NIBBLES-1, writing co from that nibble's carry-out.
REQ-025 DONE: SHALL assert done0 or done1 (owner only) for exactly one cycle, update last-served to owner, return to IDLE.
REQ-026 Latency: ack in cycle c -> done in cycle c+NIBBLES+1 (c+5 for default); next ack earliest cycle c+NIBBLES+2.
REQ-027 Requests while busy SHALL be ignored (no ack, no operand capture); requester holds req until ack.
REQ-028 ack0/ack1 SHALL never be high simultaneously; done0/done1 likewise.
REQ-029 s and co SHALL hold their last completed value until overwritten; s nibbles above k are stale during RUN and only valid in the done cycle and after.
REQ-030 Operand inputs SHALL be sampled only in the ack cycle; later changes SHALL not affect the result.
REQ-031 Arithmetic SHALL be unsigned modulo 2^W with co as bit W of a + b + ci.

Reset
REQ-032 While rst_n low at a rising edge: state IDLE, s=0, co=0, carry=0, nibble index=0, owner=0, last-served=1; ack0/1, done0/1, busy SHALL be 0 in the following cycle.
REQ-033 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.

Verification
REQ-034 Reset: rst_n low 2 cycles with req0=1 -> ack0=0, done0=0, s=0x0000, co=0, busy=0.
REQ-035 Single op: req0=1, a0=0x1234, b0=0x4321, ci0=0 in cycle c -> ack0 in c, busy c+1..c+5, done0 in c+5, s=0x5555, co=0.
REQ-036 Carry ripple: a1=0xFFFF, b1=0x0001, ci1=0 -> s=0x0000, co=1; a0=0xFFFF, b0=0x0000, ci0=1 -> s=0x0000, co=1.
REQ-037 Tie after reset: req0=req1=1 held -> ack0 first, done0, then ack1 in cycle after done0; alternation continues 0,1,0,1.
REQ-038 Busy/abort: req1 raised during requester-0 RUN -> no ack1 until IDLE; separate run with rst_n low in second RUN cycle -> no done, s=0, busy=0 next cycle.
